display_scanner: RTL
====================

# display_scanner

Drives the two-digit seven-segment display for the ALU result. It divides CLK down to the scan clock S_CLK that feeds the Switcher digit-select stage. It also double-buffers an 8-bit value so a new value takes effect only at a frame boundary, never mid-scan. SEG is registered and changes in the same cycle as S_CLK, so it always matches the digit that Switcher's D enables.

## Interface
- DIV, 50000: CLK cycles per digit phase; legal range ≥1.
- BLANK_LZ, 1: when 1, a zero high digit is blanked.

- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- VALUE  in  8  value to display; [3:0] is digit 0 (right), [7:4] is digit 1 (left).
- LOAD  in  1  one-cycle strobe; VALUE is sampled on the edge where LOAD=1.
- ACK  out  1  one-cycle pulse when a loaded value becomes displayed.
- S_CLK  out  1  scan clock to Switcher; 0 selects digit 0 (D=01), 1 selects digit 1 (D=10).
- SEG  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.

## Operation
- Prescaler CNT counts 0..DIV-1; width is ceil(log2(DIV)), minimum 1.
- At CNT==DIV-1 (the "toggle" cycle), CNT wraps to 0 and S_CLK inverts.
- A frame boundary is a toggle cycle where S_CLK goes 1→0, i.e. digit 0 is starting.
- Registers: PEND[7:0], PEND_V, DISP[7:0].
- LOAD=1: PEND←VALUE, PEND_V←1. A LOAD while PEND_V=1 overwrites PEND (latest wins); only one ACK results.
- At a frame boundary with PEND_V=1: DISP←PEND, PEND_V←0, ACK=1 for exactly that cycle.
- LOAD on a boundary cycle: the transfer uses the prior PEND contents, if PEND_V was 1. The new VALUE becomes pending and waits for the next boundary.
- SEG update occurs only on toggle cycles. SEG←glyph(nibble for the new S_CLK value), taken from the DISP value in effect after that edge. On a boundary with transfer, this is PEND[3:0].
- Blanking: with BLANK_LZ=1, new S_CLK=1 and high nibble==0, SEG←7'b1111111. Digit 0 is never blanked.
- Glyphs use standard hex, with b and d in lowercase:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset values: CNT=0, S_CLK=0, PEND=0, PEND_V=0, DISP=0, ACK=0, SEG=1000000 (glyph 0).
- RST asserted mid-frame takes effect immediately and asynchronously. Any pending value is discarded and no ACK is issued. After release, scanning restarts at digit 0 with a full DIV-cycle phase.

## Timing
- Each S_CLK phase lasts DIV cycles; a frame lasts 2·DIV cycles.
- S_CLK, SEG and ACK are all registered and change on the same CLK edge.
- LOAD-to-ACK latency is 1 to 2·DIV cycles. SEG shows the new digit 0 in the ACK cycle.
- DIV=1: S_CLK toggles every cycle, and every second cycle is a boundary.
- ACK never asserts on two consecutive cycles when DIV≥1. It never asserts without a preceding LOAD since reset.

## Test plan
- Reset: assert RST mid-phase with DIV=4 → S_CLK=0, SEG=1000000 and ACK=0 within the same cycle. After release, the first toggle occurs 4 cycles later.
- Scan: DIV=4, LOAD VALUE=8'h3A → ACK at the next boundary. Then SEG=0001000 for 4 cycles (S_CLK=0), then 0110000 for 4 cycles (S_CLK=1), repeating with S_CLK period 8.
- Blanking: VALUE=8'h05. With BLANK_LZ=1 → digit-1 phase SEG=1111111 and digit-0 phase 0010010. With BLANK_LZ=0 → digit-1 phase 1000000.
- Overwrite: LOAD 8'h11 then 8'h22 within the same frame → one ACK; display shows 22 (0100100 on both phases); 11 never appears.
- Boundary collision: with PEND=8'h44 pending, LOAD 8'h77 on the boundary cycle → 44 is displayed with ACK. 77 is displayed with a second ACK exactly 2·DIV cycles later.
- DIV=1, VALUE=8'hF0 → S_CLK alternates every cycle. SEG alternates 1000000 / 0001110, with no blanking because the high nibble is nonzero.

Source files
------------

// File: rtl/display_scanner.sv
// Two-digit seven-segment scanner: divides CLK into the digit scan clock and
// double-buffers the displayed byte so a new value only appears at a frame start.
module display_scanner #(
  parameter int DIV      = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] VALUE,
  input  logic       LOAD,
  output logic       ACK,
  output logic       S_CLK,
  output logic [6:0] SEG
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_clk_q, s_clk_d;
  logic [7:0]    pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [7:0]    disp_q, disp_d;
  logic          ack_q, ack_d;
  logic [6:0]    seg_q, seg_d;

  logic          toggle;
  logic          transfer;
  logic [3:0]    digit;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    toggle   = (cnt_q == CW'(DIV - 1));
    // A frame starts when digit 1 hands back to digit 0; only then may DISP change.
    transfer = toggle && s_clk_q && pend_v_q;

    cnt_d    = toggle ? '0 : cnt_q + CW'(1);
    s_clk_d  = toggle ? ~s_clk_q : s_clk_q;
    disp_d   = transfer ? pend_q : disp_q;
    ack_d    = transfer;

    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (LOAD) begin
      pend_d   = VALUE;
      pend_v_d = 1'b1;
    end else if (transfer) begin
      pend_v_d = 1'b0;
    end

    // SEG is computed from the post-edge digit and DISP so it lines up with S_CLK.
    digit = s_clk_d ? disp_d[7:4] : disp_d[3:0];
    seg_d = seg_q;
    if (toggle) begin
      if (s_clk_d && BLANK_LZ && (disp_d[7:4] == 4'h0)) seg_d = 7'b1111111;
      else                                              seg_d = glyph(digit);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q    <= '0;
      s_clk_q  <= 1'b0;
      pend_q   <= 8'h00;
      pend_v_q <= 1'b0;
      disp_q   <= 8'h00;
      ack_q    <= 1'b0;
      seg_q    <= 7'b1000000;
    end else begin
      cnt_q    <= cnt_d;
      s_clk_q  <= s_clk_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      disp_q   <= disp_d;
      ack_q    <= ack_d;
      seg_q    <= seg_d;
    end
  end

  assign ACK   = ack_q;
  assign S_CLK = s_clk_q;
  assign SEG   = seg_q;

endmodule
